galvo_responder: RTL and testbench

Galvo-side responder for the sequencer's galvo handshake. Each rising edge of the galvo change trigger advances to the next entry of a host-loaded position table. The block then shifts that 16-bit code to the galvo DAC over a 3-wire serial link and waits a programmable settle time. When the settle time ends, it returns a one-cycle acknowledge. It sits between the sequencer's galvo trigger/ack pins and the external DAC, and lets the system run without a separate galvo controller.

---
 rtl/galvo_responder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_galvo_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galvo_responder.sv
// -----------------------------------------------------------------------------
// galvo_responder
//
// Galvo-side responder for the sequencer's galvo handshake. Every rising edge
// of the (asynchronous) galvo change trigger fetches the next entry of a
// host-loaded position table, shifts it MSB first to the galvo DAC over a
// 3-wire serial link (SYNC_N / SCLK / DIN), waits a programmable settle time
// and then returns a single-cycle acknowledge to the sequencer.
//
// Ports
//   iCLK                   system clock (single clock domain)
//   iRST_N                 asynchronous active-low reset
//   iRESTART               synchronous pulse: abort transfer, index -> 0,
//                          clear overrun flag
//   iNUM_POSITIONS         table length used for index wrap (0 behaves as 1)
//   iSETTLE_US             settle time in microseconds, captured in LOAD
//   iWR_EN/iWR_ADDR/iWR_DATA  host write port into the position table
//   iGALVO_CHANGE_TRIGGER  asynchronous request level; rising edge = request
//   oGALVO_ACK             one-cycle pulse once the galvo has settled
//   oDAC_SYNC_N            DAC frame select, active low
//   oDAC_SCLK              DAC serial clock, idles low, DAC samples on rise
//   oDAC_DIN               DAC serial data
//   oPOSITION_INDEX        index of the most recently fetched table entry
//   oBUSY                  high whenever the sequencer is not idle
//   oOVERRUN               sticky: a request edge arrived while busy
// -----------------------------------------------------------------------------
module galvo_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int SCLK_DIV    = 4,
    parameter int CLKS_PER_US = 50
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRESTART,
    input  logic [ADDR_W-1:0] iNUM_POSITIONS,
    input  logic [15:0]       iSETTLE_US,
    input  logic              iWR_EN,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    input  logic              iGALVO_CHANGE_TRIGGER,
    output logic              oGALVO_ACK,
    output logic              oDAC_SYNC_N,
    output logic              oDAC_SCLK,
    output logic              oDAC_DIN,
    output logic [ADDR_W-1:0] oPOSITION_INDEX,
    output logic              oBUSY,
    output logic              oOVERRUN
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDR_W;
    // phase counter covers one full SCLK period (2*SCLK_DIV iCLK cycles)
    localparam int PH_W        = $clog2(2 * SCLK_DIV);
    localparam int BIT_W       = $clog2(DATA_W + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(SCLK_DIV);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [BIT_W-1:0]  BIT_DONE  = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W + 1)'(1);
    localparam logic [31:0]       CLKS_US_W = 32'(CLKS_PER_US);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_SETTLE,
        ST_ACK
    } state_t;

    // -------------------------------------------------------------------------
    // Trigger synchronizer and rising-edge detect
    // -------------------------------------------------------------------------
    logic sync_reg [SYNC_STAGES];
    logic trig_prev_reg;
    logic trig_edge;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge iCLK or negedge iRST_N) begin
                    if (!iRST_N) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= iGALVO_CHANGE_TRIGGER;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge iCLK or negedge iRST_N) begin
                    if (!iRST_N) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            trig_prev_reg <= 1'b0;
        end else begin
            trig_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Edge pulse lasts exactly one cycle regardless of how long the level is
    // held; it is consumed even when iRESTART discards it.
    assign trig_edge = sync_reg[SYNC_STAGES-1] & ~trig_prev_reg;

    // -------------------------------------------------------------------------
    // Position table: one write port, one registered read port.
    // No reset on the array so it maps onto block RAM; a read colliding with
    // a write to the same address returns the previous contents.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] table_mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [ADDR_W-1:0] next_idx_reg;

    always_ff @(posedge iCLK) begin
        if (iWR_EN) begin
            table_mem[iWR_ADDR] <= iWR_DATA;
        end
        // The read address is next_idx itself, so the word addressed in
        // FETCH is already sitting in rd_data_reg when LOAD executes.
        rd_data_reg <= table_mem[next_idx_reg];
    end

    // -------------------------------------------------------------------------
    // Index wrap: next_idx+1 compared against max(N,1) with one spare bit so
    // that an N of 2^ADDR_W-style boundary never overflows the comparison.
    // -------------------------------------------------------------------------
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W:0]   eff_num;
    logic [ADDR_W-1:0] idx_next;

    always_comb begin
        idx_inc  = {1'b0, next_idx_reg} + IDX_ONE;
        eff_num  = (iNUM_POSITIONS == '0) ? IDX_ONE : {1'b0, iNUM_POSITIONS};
        idx_next = (idx_inc >= eff_num) ? '0 : idx_inc[ADDR_W-1:0];
    end

    // -------------------------------------------------------------------------
    // Main sequencer with registered outputs
    // -------------------------------------------------------------------------
    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [PH_W-1:0]   phase_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [31:0]       settle_cnt_reg;
    logic              ack_reg;
    logic              sync_n_reg;
    logic              sclk_reg;
    logic              din_reg;
    logic [ADDR_W-1:0] pos_idx_reg;
    logic              busy_reg;
    logic              overrun_reg;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            phase_reg      <= '0;
            bit_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            next_idx_reg   <= '0;
            ack_reg        <= 1'b0;
            sync_n_reg     <= 1'b1;
            sclk_reg       <= 1'b0;
            din_reg        <= 1'b0;
            pos_idx_reg    <= '0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (iRESTART) begin
            // Abort wins over everything, including a coincident request
            // edge; the last fetched index stays visible to the host.
            state_reg    <= ST_IDLE;
            next_idx_reg <= '0;
            ack_reg      <= 1'b0;
            sync_n_reg   <= 1'b1;
            sclk_reg     <= 1'b0;
            din_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            ack_reg <= 1'b0;

            // Requests are never queued: anything arriving outside IDLE is
            // dropped and only flagged.
            if (trig_edge && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (trig_edge) begin
                        state_reg <= ST_FETCH;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    pos_idx_reg  <= next_idx_reg;
                    next_idx_reg <= idx_next;
                    state_reg    <= ST_LOAD;
                end

                ST_LOAD: begin
                    shift_reg      <= rd_data_reg;
                    settle_cnt_reg <= 32'(iSETTLE_US) * CLKS_US_W;
                    phase_reg      <= '0;
                    bit_cnt_reg    <= '0;
                    state_reg      <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (bit_cnt_reg == BIT_DONE) begin
                        // Frame complete: close it and return lines to idle.
                        sync_n_reg <= 1'b1;
                        sclk_reg   <= 1'b0;
                        din_reg    <= 1'b0;
                        state_reg  <= ST_SETTLE;
                    end else begin
                        sync_n_reg <= 1'b0;
                        // Low for the first half of each bit, high for the
                        // second half; DIN changes only at bit start so it is
                        // stable well before the sampling (rising) edge.
                        sclk_reg   <= (phase_reg >= PH_HIGH);
                        if (phase_reg == '0) begin
                            din_reg   <= shift_reg[DATA_W-1];
                            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        end
                        if (phase_reg == PH_LAST) begin
                            phase_reg   <= '0;
                            bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                        end else begin
                            phase_reg <= phase_reg + PH_ONE;
                        end
                    end
                end

                ST_SETTLE: begin
                    // A loaded count of 0 or 1 both give a one-cycle settle.
                    if (settle_cnt_reg <= 32'd1) begin
                        ack_reg   <= 1'b1;
                        state_reg <= ST_ACK;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 32'd1;
                    end
                end

                ST_ACK: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign oGALVO_ACK      = ack_reg;
    assign oDAC_SYNC_N     = sync_n_reg;
    assign oDAC_SCLK       = sclk_reg;
    assign oDAC_DIN        = din_reg;
    assign oPOSITION_INDEX = pos_idx_reg;
    assign oBUSY           = busy_reg;
    assign oOVERRUN        = overrun_reg;

endmodule

// File: tb/tb_galvo_responder.sv
// -----------------------------------------------------------------------------
// tb_galvo_responder
//
// Directed sequence of galvo handshakes with randomized table contents,
// table lengths, settle times and trigger hold times. Expected words, indexes
// and cycle timings come from a small reference model (table array plus a
// modulo position counter and closed-form timing).
// -----------------------------------------------------------------------------
module tb_galvo_responder;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 8;
    localparam int SCLK_DIV    = 4;
    localparam int CLKS_PER_US = 50;
    localparam int SHIFT_CYC   = 2 * SCLK_DIV * DATA_W;
    // edge sampled at k -> seen at k+2 -> SYNC_N falls three cycles later
    localparam int BUSY_AT     = 3;
    localparam int FALL_AT     = 6;

    logic              iCLK;
    logic              iRST_N;
    logic              iRESTART;
    logic [ADDR_W-1:0] iNUM_POSITIONS;
    logic [15:0]       iSETTLE_US;
    logic              iWR_EN;
    logic [ADDR_W-1:0] iWR_ADDR;
    logic [DATA_W-1:0] iWR_DATA;
    logic              iGALVO_CHANGE_TRIGGER;
    logic              oGALVO_ACK;
    logic              oDAC_SYNC_N;
    logic              oDAC_SCLK;
    logic              oDAC_DIN;
    logic [ADDR_W-1:0] oPOSITION_INDEX;
    logic              oBUSY;
    logic              oOVERRUN;

    galvo_responder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SCLK_DIV    (SCLK_DIV),
        .CLKS_PER_US (CLKS_PER_US)
    ) dut (
        .iCLK                  (iCLK),
        .iRST_N                (iRST_N),
        .iRESTART              (iRESTART),
        .iNUM_POSITIONS        (iNUM_POSITIONS),
        .iSETTLE_US            (iSETTLE_US),
        .iWR_EN                (iWR_EN),
        .iWR_ADDR              (iWR_ADDR),
        .iWR_DATA              (iWR_DATA),
        .iGALVO_CHANGE_TRIGGER (iGALVO_CHANGE_TRIGGER),
        .oGALVO_ACK            (oGALVO_ACK),
        .oDAC_SYNC_N           (oDAC_SYNC_N),
        .oDAC_SCLK             (oDAC_SCLK),
        .oDAC_DIN              (oDAC_DIN),
        .oPOSITION_INDEX       (oPOSITION_INDEX),
        .oBUSY                 (oBUSY),
        .oOVERRUN              (oOVERRUN)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    int          model_next = 0;
    int          model_n = 1;
    bit          model_ovr = 1'b0;
    logic [15:0] tbl_model [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [15:0] data);
        @(negedge iCLK);
        iWR_EN   = 1'b1;
        iWR_ADDR = addr[ADDR_W-1:0];
        iWR_DATA = data;
        tbl_model[addr] = data;
        @(negedge iCLK);
        iWR_EN   = 1'b0;
    endtask

    task automatic set_len(input int n);
        iNUM_POSITIONS = n[ADDR_W-1:0];
        model_n = (n == 0) ? 1 : n;
    endtask

    task automatic do_restart();
        @(negedge iCLK);
        iRESTART = 1'b1;
        @(negedge iCLK);
        iRESTART = 1'b0;
        model_next = 0;
        model_ovr  = 1'b0;
    endtask

    // One complete handshake: raise the trigger, watch every cycle, rebuild
    // the shifted word from SCLK rising edges and time every event relative
    // to the trigger. With ovr set a second request pulse lands mid-SHIFT.
    task automatic run_transfer(input string tag, input int settle_us, input bit ovr);
        int          n, hold, limit, exp_idx, exp_settle;
        int          busy_n, fall_n, rise_n, ack_n, acks, falls, nbits;
        logic        prev_sclk, prev_sync, rise_sclk, rise_din, busy_after;
        logic [15:0] word;

        exp_idx    = model_next;
        exp_settle = settle_us * CLKS_PER_US;
        if (exp_settle < 1) exp_settle = 1;
        limit      = FALL_AT + SHIFT_CYC + exp_settle + 40;
        hold       = ovr ? 20 : int'($urandom_range(1, 200));

        busy_n = -1; fall_n = -1; rise_n = -1; ack_n = -1;
        acks = 0; falls = 0; nbits = 0; word = '0;
        prev_sclk = 1'b0; prev_sync = 1'b1;
        rise_sclk = 1'bx; rise_din = 1'bx; busy_after = 1'b1;

        @(negedge iCLK);
        iSETTLE_US = settle_us[15:0];
        iGALVO_CHANGE_TRIGGER = 1'b1;
        n = 0;
        while (n < limit && !(ack_n >= 0 && n >= ack_n + 3)) begin
            @(negedge iCLK);
            n++;
            if (n == hold) iGALVO_CHANGE_TRIGGER = 1'b0;
            if (ovr && n == 40) iGALVO_CHANGE_TRIGGER = 1'b1;
            if (ovr && n == 50) iGALVO_CHANGE_TRIGGER = 1'b0;
            if (oBUSY && busy_n < 0) busy_n = n;
            if (!oDAC_SYNC_N && prev_sync) begin
                falls++;
                if (fall_n < 0) fall_n = n;
            end
            if (oDAC_SYNC_N && !prev_sync && rise_n < 0) begin
                rise_n    = n;
                rise_sclk = oDAC_SCLK;
                rise_din  = oDAC_DIN;
            end
            if (oDAC_SCLK && !prev_sclk && !oDAC_SYNC_N) begin
                word = {word[14:0], oDAC_DIN};
                nbits++;
            end
            if (oGALVO_ACK) begin
                acks++;
                if (ack_n < 0) ack_n = n;
            end
            if (ack_n >= 0 && n == ack_n + 1) busy_after = oBUSY;
            prev_sclk = oDAC_SCLK;
            prev_sync = oDAC_SYNC_N;
        end
        iGALVO_CHANGE_TRIGGER = 1'b0;
        if (ovr) model_ovr = 1'b1;

        check({tag, "_busy_rise"}, busy_n, BUSY_AT);
        check({tag, "_sync_fall"}, fall_n, FALL_AT);
        check({tag, "_sync_rise"}, rise_n, FALL_AT + SHIFT_CYC);
        check({tag, "_frames"}, falls, 1);
        check({tag, "_bits"}, nbits, DATA_W);
        check({tag, "_word"}, word, tbl_model[exp_idx]);
        check({tag, "_idle_lines"}, {rise_sclk, rise_din}, 2'b00);
        check({tag, "_ack_time"}, ack_n, FALL_AT + SHIFT_CYC + exp_settle);
        check({tag, "_ack_count"}, acks, 1);
        check({tag, "_busy_fall"}, busy_after, 1'b0);
        check({tag, "_index"}, oPOSITION_INDEX, exp_idx);
        check({tag, "_overrun"}, oOVERRUN, model_ovr);
        $display("xfer %s idx=%0d word=%h settle_us=%0d ack_at=%0d acks=%0d",
                 tag, exp_idx, word, settle_us, ack_n, acks);

        model_next = (model_next + 1) % model_n;
        repeat (4) @(negedge iCLK);
    endtask

    // Watch for a quiet interval: no frame, no ack, not busy.
    task automatic expect_quiet(input string tag, input int cycles);
        int acks, falls, busy_seen;
        acks = 0; falls = 0; busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge iCLK);
            if (oGALVO_ACK) acks++;
            if (!oDAC_SYNC_N) falls++;
            if (oBUSY) busy_seen++;
        end
        check({tag, "_no_ack"}, acks, 0);
        check({tag, "_no_frame"}, falls, 0);
        check({tag, "_no_busy"}, busy_seen, 0);
        $display("quiet %s cycles=%0d acks=%0d frame_cycles=%0d", tag, cycles, acks, falls);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},     oGALVO_ACK, 1'b0);
        check({tag, "_sync_n"},  oDAC_SYNC_N, 1'b1);
        check({tag, "_sclk"},    oDAC_SCLK, 1'b0);
        check({tag, "_din"},     oDAC_DIN, 1'b0);
        check({tag, "_index"},   oPOSITION_INDEX, 0);
        check({tag, "_busy"},    oBUSY, 1'b0);
        check({tag, "_overrun"}, oOVERRUN, 1'b0);
    endtask

    initial begin
        int n_rand, k_rand;

        iRST_N = 1'b0;
        iRESTART = 1'b0;
        iWR_EN = 1'b0;
        iWR_ADDR = '0;
        iWR_DATA = '0;
        iGALVO_CHANGE_TRIGGER = 1'b0;
        iSETTLE_US = '0;
        set_len(4);
        repeat (3) @(negedge iCLK);
        check_reset_outputs("reset");
        iRST_N = 1'b1;

        for (int i = 0; i < 8; i++) write_entry(i, 16'($urandom));
        write_entry(0, 16'hA5C3);

        // Basic transfer, zero settle
        run_transfer("basic", 0, 1'b0);

        // Wrap with N=3
        set_len(3);
        do_restart();
        for (int i = 0; i < 4; i++) run_transfer("wrap", 0, 1'b0);

        // Settle of 2 us
        run_transfer("settle", 2, 1'b0);

        // Overrun: second request during SHIFT, next request uses index 1
        do_restart();
        check("ovr_clear", oOVERRUN, 1'b0);
        run_transfer("ovr", 0, 1'b1);
        run_transfer("ovr_next", 0, 1'b0);

        // Restart mid-SHIFT (overrun is still set from above)
        @(negedge iCLK);
        iGALVO_CHANGE_TRIGGER = 1'b1;
        repeat (60) @(negedge iCLK);
        check("rst_mid_sync_low", oDAC_SYNC_N, 1'b0);
        k_rand = model_next;
        iRESTART = 1'b1;
        @(negedge iCLK);
        iRESTART = 1'b0;
        iGALVO_CHANGE_TRIGGER = 1'b0;
        model_next = 0;
        model_ovr  = 1'b0;
        check("restart_sync_n", oDAC_SYNC_N, 1'b1);
        check("restart_lines", {oDAC_SCLK, oDAC_DIN}, 2'b00);
        check("restart_overrun", oOVERRUN, 1'b0);
        check("restart_index_kept", oPOSITION_INDEX, k_rand);
        expect_quiet("restart", 300);
        run_transfer("after_restart", 0, 1'b0);

        // Randomized table lengths, contents and settle times
        for (int r = 0; r < 3; r++) begin
            n_rand = int'($urandom_range(1, 6));
            for (int i = 0; i < n_rand; i++) write_entry(i, 16'($urandom));
            set_len(n_rand);
            do_restart();
            k_rand = int'($urandom_range(2, 4));
            for (int t = 0; t < k_rand; t++)
                run_transfer("rand", int'($urandom_range(0, 1)), 1'b0);
        end

        // N=0 behaves as a single-entry table
        set_len(0);
        do_restart();
        write_entry(0, 16'($urandom));
        run_transfer("n0", 0, 1'b0);
        run_transfer("n0", 0, 1'b0);

        // Asynchronous reset during SETTLE
        set_len(4);
        do_restart();
        write_entry(1, 16'($urandom));
        run_transfer("pre_reset", 0, 1'b0);
        @(negedge iCLK);
        iSETTLE_US = 16'd3;
        iGALVO_CHANGE_TRIGGER = 1'b1;
        repeat (FALL_AT + SHIFT_CYC + 20) @(negedge iCLK);
        check("settle_busy", oBUSY, 1'b1);
        #2;
        iRST_N = 1'b0;
        iGALVO_CHANGE_TRIGGER = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_next = 0;
        model_ovr  = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        expect_quiet("post_reset", 400);
        check("post_reset_index", oPOSITION_INDEX, 0);

        write_entry(0, 16'($urandom));
        run_transfer("final", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
